// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Shares one decoder across digits, snapshots inputs per frame, guards against ghosting and flashes end-of-play states.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 1000,
  parameter int BLINK_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  state,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an,
  output logic [3:0]  nib,
  output logic [2:0]  dec_state,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT  = CW'(GUARD);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic [31:0]   sh_dig;
  logic [7:0]    sh_en;

  logic tick;
  logic wrap;
  logic blank;
  logic dark;

  always_comb begin
    tick  = (cnt == CNT_LAST);
    wrap  = tick && (idx == 3'd7);
    blank = state[2] && blink_phase;
    dark  = (cnt < GUARD_CNT) || !sh_en[idx] || blank;
  end

  // Slot/digit counters plus the frame-coherent snapshot and blink timing, all advanced on slot ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= 3'd0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      sh_dig      <= 32'h0;
      sh_en       <= 8'h0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (wrap) begin
        sh_dig <= digits;
        sh_en  <= digit_en;
        if (fcnt == FCNT_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end

  // Pin registers; nib stays driven while dark so the decoder input never floats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      nib        <= 4'h0;
      dec_state  <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      an         <= dark ? 8'hFF : ~(8'b1 << idx);
      nib        <= sh_dig[{idx, 2'b00} +: 4];
      dec_state  <= state;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes per-edge expectations, a monitor pops and compares on the falling edge.
module tb_seg_scan_ctrl;

  localparam int REFRESH_DIV  = 4;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 8 * REFRESH_DIV;

  logic        clk;
  logic        rst_n;
  logic [2:0]  state;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [7:0]  an;
  logic [3:0]  nib;
  logic [2:0]  dec_state;
  logic        frame_tick;

  typedef struct {
    int         edge_no;
    logic [7:0] an;
    logic [3:0] nib;
    logic [2:0] dec_state;
    logic       frame_tick;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int          n_edge;
  int          wraps;
  logic [31:0] tb_sd;
  logic [7:0]  tb_se;

  seg_scan_ctrl #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .digits    (digits),
    .digit_en  (digit_en),
    .an        (an),
    .nib       (nib),
    .dec_state (dec_state),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for the given number of edges; every reset edge must leave the pins at their idle values.
  task automatic apply_reset(input int cycles);
    exp_t e;
    rst_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      e.edge_no    = -1;
      e.an         = 8'hFF;
      e.nib        = 4'h0;
      e.dec_state  = 3'd0;
      e.frame_tick = 1'b0;
      exp_q.push_back(e);
    end
    n_edge = 0;
    wraps  = 0;
    tb_sd  = 32'h0;
    tb_se  = 8'h0;
    rst_n  = 1'b1;
  endtask

  // One running edge: expectation derived from slot position, the frame's snapshot and the blink half-period.
  task automatic apply_stimulus();
    exp_t e;
    int   cnt_m;
    int   idx_m;
    logic blank_m;
    @(posedge clk);
    #1;
    n_edge++;
    cnt_m   = (n_edge - 1) % REFRESH_DIV;
    idx_m   = ((n_edge - 1) / REFRESH_DIV) % 8;
    blank_m = state[2] && (((wraps / BLINK_FRAMES) % 2) == 1);
    e.edge_no    = n_edge;
    e.an         = (cnt_m < GUARD || !tb_se[idx_m] || blank_m) ? 8'hFF : ~(8'h01 << idx_m);
    e.nib        = tb_sd[idx_m*4 +: 4];
    e.dec_state  = state;
    e.frame_tick = (n_edge % FRAME == 0);
    exp_q.push_back(e);
    if (n_edge % FRAME == 0) begin
      tb_sd = digits;
      tb_se = digit_en;
      wraps++;
    end
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (an !== e.an) begin
      errors++;
      $display("[TB] FAIL an edge=%0d got=%h want=%h", e.edge_no, an, e.an);
    end
    checks++;
    if (nib !== e.nib) begin
      errors++;
      $display("[TB] FAIL nib edge=%0d got=%h want=%h", e.edge_no, nib, e.nib);
    end
    checks++;
    if (dec_state !== e.dec_state) begin
      errors++;
      $display("[TB] FAIL dec_state edge=%0d got=%0d want=%0d", e.edge_no, dec_state, e.dec_state);
    end
    checks++;
    if (frame_tick !== e.frame_tick) begin
      errors++;
      $display("[TB] FAIL frame_tick edge=%0d got=%b want=%b", e.edge_no, frame_tick, e.frame_tick);
    end
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("[TB] FAIL one_anode edge=%0d got=%h want=at most one low bit", e.edge_no, an);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    n_edge   = 0;
    wraps    = 0;
    tb_sd    = 32'h0;
    tb_se    = 8'h0;

    $display("[TB] reset and dark first frame");
    state    = 3'd3;
    digits   = 32'h12345678;
    digit_en = 8'hFF;
    apply_reset(3);
    state = 3'd0;
    repeat (36) apply_stimulus();

    $display("[TB] scan order");
    digits = 32'h89ABCDEF;
    apply_reset(1);
    repeat (64) apply_stimulus();

    $display("[TB] enable mask");
    digit_en = 8'h0F;
    apply_reset(1);
    repeat (64) apply_stimulus();

    $display("[TB] mid-frame snapshot");
    digit_en = 8'hFF;
    digits   = 32'h00000000;
    apply_reset(1);
    for (int i = 0; i < 72; i++) begin
      apply_stimulus();
      if (n_edge == 45) digits = 32'hFFFFFFFF;
    end

    $display("[TB] flash mode");
    digits = 32'h89ABCDEF;
    state  = 3'd5;
    apply_reset(1);
    for (int i = 0; i < 212; i++) begin
      apply_stimulus();
      if (n_edge == 202) state = 3'd2;
    end

    $display("[TB] mid-frame reset");
    state = 3'd0;
    apply_reset(1);
    while (n_edge < 45) apply_stimulus();
    apply_reset(1);
    repeat (40) apply_stimulus();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
